// File: rtl/motor_ramp_ctrl.sv
// Slew-rate limiter + command watchdog: signed target -> ramped |speed| and dir for one motor.
// Latency: target registered 1 cycle after cmd_valid; cur moves by STEP on each prescaler tick.
// Backpressure: none; cmd_valid is a fire-and-forget strobe, a newer command simply overwrites tgt.
module motor_ramp_ctrl #(
    parameter int STEP          = 10,
    parameter int TICK_DIV      = 100000,
    parameter int MAX_SPEED     = 400,
    parameter int TIMEOUT_TICKS = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic signed [9:0] cmd_speed,
    input  logic              cmd_run,
    output logic [9:0]        speed,
    output logic              dir,
    output logic              run_en,
    output logic              at_target,
    output logic              timeout
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [PW-1:0]        PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0]        WD_LAST  = WW'(TIMEOUT_TICKS - 1);
    localparam logic [WW-1:0]        WD_MAX   = WW'(TIMEOUT_TICKS);
    localparam logic signed [10:0]   MAXS     = 11'(MAX_SPEED);
    localparam logic signed [10:0]   NEG_MAXS = -11'(MAX_SPEED);
    localparam logic signed [10:0]   STEPS    = 11'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PW-1:0]       prescaler;
    logic                tick;
    logic [WW-1:0]       wd;
    logic                wd_expire;
    logic signed [10:0]  cur;
    logic signed [10:0]  tgt;
    logic signed [10:0]  cur_nxt;
    logic signed [10:0]  tgt_nxt;
    logic                timeout_nxt;
    logic                dir_nxt;
    logic signed [10:0]  cmd_ext;
    logic signed [10:0]  cmd_tgt;
    logic signed [10:0]  cur_up;
    logic signed [10:0]  cur_dn;
    logic signed [10:0]  cur_neg;

    assign tick      = (prescaler == PS_LAST);
    // Expiry is the single tick on which wd would reach the limit; it does not repeat while saturated.
    assign wd_expire = tick && (wd == WD_LAST);

    // Free-running ramp-tick prescaler, wraps at TICK_DIV-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Watchdog: ticks since last command, saturating; a command always restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd <= '0;
        end else if (cmd_valid) begin
            wd <= '0;
        end else if (tick && (wd != WD_MAX)) begin
            wd <= wd + 1'b1;
        end
    end

    // Clamp the incoming command into +/-MAX_SPEED; a stop command targets zero.
    always_comb begin
        cmd_ext = {cmd_speed[9], cmd_speed};
        cmd_tgt = '0;
        if (cmd_run) begin
            if (cmd_ext > MAXS) begin
                cmd_tgt = MAXS;
            end else if (cmd_ext < NEG_MAXS) begin
                cmd_tgt = NEG_MAXS;
            end else begin
                cmd_tgt = cmd_ext;
            end
        end
    end

    // Next target/timeout: a command beats a simultaneous watchdog expiry.
    always_comb begin
        tgt_nxt     = tgt;
        timeout_nxt = timeout;
        if (cmd_valid) begin
            tgt_nxt     = cmd_tgt;
            timeout_nxt = 1'b0;
        end else if (wd_expire) begin
            tgt_nxt     = '0;
            timeout_nxt = 1'b1;
        end
    end

    // Next cur: one STEP toward the current (old) target per tick, never past it.
    always_comb begin
        cur_up  = cur + STEPS;
        cur_dn  = cur - STEPS;
        cur_nxt = cur;
        if (tick) begin
            if (cur < tgt) begin
                cur_nxt = (cur_up > tgt) ? tgt : cur_up;
            end else if (cur > tgt) begin
                cur_nxt = (cur_dn < tgt) ? tgt : cur_dn;
            end
        end
    end

    // Direction follows the sign of cur and holds across zero.
    always_comb begin
        dir_nxt = dir;
        if (cur_nxt > 11'sd0) begin
            dir_nxt = 1'b1;
        end else if (cur_nxt < 11'sd0) begin
            dir_nxt = 1'b0;
        end
    end

    // Ramp datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur     <= '0;
            tgt     <= '0;
            timeout <= 1'b0;
            dir     <= 1'b1;
        end else begin
            cur     <= cur_nxt;
            tgt     <= tgt_nxt;
            timeout <= timeout_nxt;
            dir     <= dir_nxt;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state is judged on the values cur/tgt take this edge, so state stays in step with them.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((tgt_nxt != 11'sd0) || (cur_nxt != 11'sd0)) begin
                    state_nxt = RAMP;
                end
            end
            RAMP: begin
                if ((cur_nxt == 11'sd0) && (tgt_nxt == 11'sd0)) begin
                    state_nxt = IDLE;
                end else if (cur_nxt == tgt_nxt) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (tgt_nxt != cur_nxt) begin
                    state_nxt = RAMP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded straight from registers.
    always_comb begin
        cur_neg   = -cur;
        speed     = cur[10] ? cur_neg[9:0] : cur[9:0];
        run_en    = (state != IDLE);
        at_target = (cur == tgt);
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed scenarios plus random commands against an integer model.
// Latency: model advances once per clock edge, outputs sampled 1 time unit after the edge.
// Backpressure: none; the bench drives cmd_valid strobes freely.
module tb_motor_ramp_ctrl;

    localparam int STEP = 50;
    localparam int TD   = 4;
    localparam int MS   = 400;
    localparam int TO   = 100;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic signed [9:0] cmd_speed = '0;
    logic              cmd_run = 1'b0;
    logic [9:0]        speed;
    logic              dir;
    logic              run_en;
    logic              at_target;
    logic              timeout;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, plain integers.
    int m_pc, m_cur, m_tgt, m_wd, m_to, m_dir;

    motor_ramp_ctrl #(
        .STEP(STEP), .TICK_DIV(TD), .MAX_SPEED(MS), .TIMEOUT_TICKS(TO)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_speed(cmd_speed),
        .cmd_run(cmd_run), .speed(speed), .dir(dir), .run_en(run_en),
        .at_target(at_target), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int clamp(input int s);
        if (s > MS) return MS;
        if (s < -MS) return -MS;
        return s;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_cur = 0; m_tgt = 0; m_wd = 0; m_to = 0; m_dir = 1;
    endtask

    task automatic model_step(input bit v, input int s, input bit r);
        bit tk;
        bit expire;
        int old_tgt;
        tk      = (m_pc == TD - 1);
        expire  = 1'b0;
        old_tgt = m_tgt;
        m_pc    = tk ? 0 : m_pc + 1;
        if (tk) begin
            if (m_cur < old_tgt)      m_cur = (m_cur + STEP > old_tgt) ? old_tgt : m_cur + STEP;
            else if (m_cur > old_tgt) m_cur = (m_cur - STEP < old_tgt) ? old_tgt : m_cur - STEP;
            if (m_wd < TO) begin
                m_wd++;
                if (m_wd == TO) expire = 1'b1;
            end
        end
        if (v) begin
            m_tgt = r ? clamp(s) : 0;
            m_wd  = 0;
            m_to  = 0;
        end else if (expire) begin
            m_tgt = 0;
            m_to  = 1;
        end
        if (m_cur > 0)      m_dir = 1;
        else if (m_cur < 0) m_dir = 0;
    endtask

    task automatic check_all();
        chk("speed", int'(speed), iabs(m_cur));
        chk("dir", int'(dir), m_dir);
        chk("run_en", int'(run_en), (m_cur != 0 || m_tgt != 0) ? 1 : 0);
        chk("at_target", int'(at_target), (m_cur == m_tgt) ? 1 : 0);
        chk("timeout", int'(timeout), m_to);
    endtask

    // One clock: drive inputs, model the edge, compare just after it.
    task automatic cyc(input bit v, input int s, input bit r);
        cmd_valid = v;
        cmd_speed = 10'(s);
        cmd_run   = r;
        @(posedge clock);
        model_step(v, s, r);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
    endtask

    // Asynchronous reset raised between edges; outputs must clear without a clock.
    task automatic do_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_speed", int'(speed), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_run_en", int'(run_en), 0);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_timeout", int'(timeout), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit hit;
        model_reset();
        do_reset();

        // Ramp up to +200.
        cyc(1'b1, 200, 1'b1);
        chk("ramp_run_en_next", int'(run_en), 1);
        idle(20);
        chk("ramp_speed", int'(speed), 200);
        chk("ramp_dir", int'(dir), 1);
        chk("ramp_at_target", int'(at_target), 1);

        // Reversal through zero to -120; run_en must never drop.
        cyc(1'b1, -120, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 0, 1'b0);
            chk("rev_run_en", int'(run_en), 1);
        end
        chk("rev_speed", int'(speed), 120);
        chk("rev_dir", int'(dir), 0);

        // Clamp -512 to -400, then stop.
        cyc(1'b1, -512, 1'b1);
        idle(80);
        chk("clamp_speed", int'(speed), 400);
        cyc(1'b1, 123, 1'b0);
        idle(50);
        chk("stop_speed", int'(speed), 0);
        chk("stop_run_en", int'(run_en), 0);
        chk("stop_dir", int'(dir), 0);

        // Hold +200 and refresh on the exact watchdog expiry cycle.
        cyc(1'b1, 200, 1'b1);
        idle(20);
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (m_wd == TO - 1 && m_pc == TD - 1) begin
                cyc(1'b1, 200, 1'b1);
                hit = 1'b1;
            end else begin
                cyc(1'b0, 0, 1'b0);
            end
        end
        chk("wd_edge_reached", int'(hit), 1);
        chk("wd_edge_timeout", int'(timeout), 0);
        chk("wd_edge_speed", int'(speed), 200);

        // Let the watchdog expire and ramp down.
        idle(TO * TD + 40);
        chk("wd_timeout", int'(timeout), 1);
        chk("wd_speed", int'(speed), 0);
        chk("wd_run_en", int'(run_en), 0);
        cyc(1'b1, 50, 1'b1);
        chk("wd_clear", int'(timeout), 0);
        idle(10);

        // Mid-ramp reset at +150 heading to +400.
        do_reset();
        cyc(1'b1, 400, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cyc(1'b0, 0, 1'b0);
            if (m_cur == 150) hit = 1'b1;
        end
        chk("mid_reached_150", int'(hit), 1);
        chk("mid_speed_pre", int'(speed), 150);
        do_reset();
        idle(20);
        chk("mid_idle_run_en", int'(run_en), 0);
        chk("mid_idle_speed", int'(speed), 0);

        // Random commands, frequent then sparse (sparse lets the watchdog fire).
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0)
                cyc(1'b1, int'($urandom_range(0, 1023)) - 512, ($urandom_range(0, 3) != 0));
            else
                cyc(1'b0, int'($urandom_range(0, 1023)) - 512, 1'b1);
        end
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 499) == 0)
                cyc(1'b1, int'($urandom_range(0, 1023)) - 512, 1'b1);
            else
                cyc(1'b0, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
# motor_ramp_ctrl

Slew-rate limiter and command watchdog between the Bluetooth command path (bluetooth_to_motor / control loop) and a MotorDriver instance. Converts a signed target speed into a ramped magnitude plus direction, so a step command never jumps the stepper speed abruptly. A reversal ramps through zero. If commands stop arriving, the block ramps the motor down to a stop. One instance drives one motor.

## Interface
Parameters:
- STEP, default 10: speed units added/subtracted per ramp tick (1..MAX_SPEED).
- TICK_DIV, default 100000: clocks per ramp tick (≥1; 1 ms at 100 MHz).
- MAX_SPEED, default 400: magnitude clamp for targets (1..511).
- TIMEOUT_TICKS, default 500: ramp ticks without cmd_valid before forced stop (≥1).

Ports:
- clock  in  1  system clock (CLOCK_100).
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- cmd_valid  in  1  one-cycle strobe; latch cmd_speed/cmd_run.
- cmd_speed  in  10  signed target speed; positive = forward.
- cmd_run  in  1  when 0 at strobe, target is forced to 0.
- speed  out  10  unsigned |cur|, to MotorDriver speed.
- dir  out  1  1 = forward, 0 = reverse, to MotorDriver dir_in.
- run_en  out  1  high whenever state ≠ IDLE.
- at_target  out  1  cur == tgt.
- timeout  out  1  watchdog expired; sticky until next cmd_valid.

## Operation
- Internal registers:
  - tgt: signed 11-bit.
  - cur: signed 11-bit.
  - prescaler: counts 0..TICK_DIV-1. It is free-running and wraps, and the tick pulse fires on wrap.
  - wd: counts ticks since the last cmd_valid, saturating at TIMEOUT_TICKS.
- On cmd_valid:
  - tgt ← cmd_run ? clamp(cmd_speed, −MAX_SPEED, +MAX_SPEED) : 0.
  - wd ← 0 and timeout ← 0.
  - Example: −512 clamps to −MAX_SPEED.
- On a tick:
  - If cur < tgt: cur ← min(cur+STEP, tgt).
  - If cur > tgt: cur ← max(cur−STEP, tgt).
  - cur never overshoots tgt.
  - Signed arithmetic, so a reversal passes through 0 naturally.
- Watchdog:
  - wd increments on each tick.
  - When wd reaches TIMEOUT_TICKS: tgt ← 0 and timeout ← 1.
- dir:
  - 1 if cur > 0, 0 if cur < 0.
  - Holds its last value when cur == 0.
- State machine:
  - IDLE (cur=0, tgt=0) → RAMP when tgt ≠ 0.
  - RAMP → HOLD when cur == tgt ≠ 0.
  - RAMP → IDLE when cur == 0 and tgt == 0.
  - HOLD → RAMP when tgt ≠ cur. A new target and a watchdog stop both cause this.
- run_en stays 1 in RAMP even while cur crosses 0 during a reversal.

## Timing
- Reset values:
  - Outputs: speed=0, dir=1, run_en=0, at_target=1, timeout=0.
  - Internals: cur=0, tgt=0, prescaler=0, wd=0, state=IDLE.
  - Reset is asynchronous. Mid-ramp reset zeroes everything immediately, with no ramp-down.
- Latency:
  - cmd_valid in cycle N → tgt visible in cycle N+1.
  - cur first moves on the first tick after N+1.
- All outputs are pure functions of registers. They update the cycle after the tick or strobe that changed them.
- Simultaneous events:
  - cmd_valid on a tick cycle: the step uses the old tgt; the new tgt applies from the next tick.
  - cmd_valid in the same cycle as watchdog expiry: cmd_valid wins, so tgt = new command and timeout stays 0.
- Boundary cases:
  - TICK_DIV=1: tick every cycle.
  - |tgt−cur| < STEP: cur lands exactly on tgt in one tick.
  - cmd_valid with an unchanged value: only resets the watchdog; no state change.
- Overflow: cur stays within ±MAX_SPEED, so 11-bit signed intermediate (cur±STEP) cannot overflow.

## Test plan
Bench parameters: STEP=50, TICK_DIV=4, MAX_SPEED=400, TIMEOUT_TICKS=100.

- **Reset:** assert reset mid-cycle → outputs immediately show speed=0, dir=1, run_en=0, at_target=1, timeout=0.
- **Ramp up:** cmd_valid with cmd_speed=+200, cmd_run=1 →
  - speed steps 50, 100, 150, 200 on four successive ticks, 4 clocks apart; dir=1.
  - run_en=1 from the cycle after the strobe.
  - at_target=1 after the 4th tick; state HOLD.
- **Reversal:** from HOLD at +200, cmd_speed=−120 →
  - cur goes 150, 100, 50, 0, −50, −100, −120, so speed shows 150, 100, 50, 0, 50, 100, 120.
  - dir flips to 0 at cur=−50; run_en stays 1 throughout.
- **Clamp and stop:**
  - cmd_speed=−512 → tgt=−400, and cur settles at −400.
  - Then cmd_run=0 → ramps to 0, state IDLE, run_en=0, dir holds 0.
- **Watchdog:** hold at +200, then issue no strobes →
  - On the 100th tick: timeout=1, tgt=0; ramps down 150, 100, 50, 0; run_en=0.
  - A subsequent cmd_valid clears timeout.
  - Also drive cmd_valid on the exact expiry cycle → timeout stays 0.
- **Mid-ramp reset:** at cur=+150 ramping to +400, assert reset → speed=0, run_en=0 immediately. After release, stays IDLE until the next cmd_valid.
